fmap_stream_tx: RTL and testbench
=================================

// Module: fmap_stream_tx
// PURPOSE
//  Transmit side of the ternary feature-map stream consumed by the convolution core.
//  On start, streams 9 kernel weights (w_out/w_req), then one raster frame of 2-bit ternary
//  pixels (d_out with x1/y1 coordinates) from a 1-cycle-latency sync-read memory, then a zero
//  flush row so the core can drain its window. One pixel/weight per clock.
// PARAMETERS
//  DATA_WIDTH  2    ternary code width (00=0, 01=+1, 11=-1, 10 reserved)
//  MAX_DIM     28   max frame side length
//  ADDR_W      10   memory address width
//  WGT_BASE    784  address of weight 0; weights occupy WGT_BASE..WGT_BASE+8
// PORTS
//  clk          in   1           clock
//  reset        in   1           async reset, active high
//  start        in   1           begin transfer (sampled in IDLE only)
//  input_depth  in   5           frame side N, legal 3..MAX_DIM, sampled at start
//  mem_rd       out  1           memory read strobe
//  mem_addr     out  ADDR_W      memory read address
//  mem_data     in   DATA_WIDTH  read data, valid 1 cycle after mem_rd
//  w_out        out  DATA_WIDTH  weight value
//  w_req        out  1           w_out valid
//  d_out        out  DATA_WIDTH  pixel value
//  x1           out  5           pixel column
//  y1           out  5           pixel row
//  pix_valid    out  1           d_out/x1/y1 valid
//  busy         out  1           high in any state except IDLE
//  done         out  1           1-cycle pulse at end of transfer
//  err          out  1           1-cycle pulse: illegal input_depth at start
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; internal N, counters cleared. Async: takes effect
//   immediately mid-transfer; no done pulse; stream restarts only on a new start.
//  FSM: IDLE -> WGT (start & 3<=input_depth<=MAX_DIM) ; IDLE -> IDLE + err pulse otherwise.
//   WGT -> PIX after 9th weight read issued; PIX -> FLUSH after address N*N-1 issued;
//   FLUSH -> DONE after N flush cycles; DONE -> IDLE unconditionally (done=1 in DONE).
//  Start while busy: ignored. input_depth changes while busy: ignored (N latched).
//  WGT: mem_rd=1, mem_addr=WGT_BASE+k, k=0..8, one per cycle; w_out<=mem_data, w_req=1
//   one cycle after each read, so 9 consecutive w_req cycles.
//  PIX: mem_addr=y*N+x, raster order x fastest, x wraps N-1->0 with y+1. 1-cycle read
//   latency: d_out, x1, y1, pix_valid update on the same edge, 1 clk after the address,
//   i.e. x1/y1 are the delayed coordinates of the returned data. Last weight and first pixel
//   are back-to-back (no bubble). Row address computed by incrementing accumulator (+1),
//   no multiplier.
//  FLUSH: no reads; d_out=0, pix_valid=1, y1=N, x1 counts 0..N-1; then pix_valid=0.
//  Outside WGT/PIX/FLUSH output windows: w_req=0, pix_valid=0, d_out/w_out/x1/y1 hold 0.
//  Reserved code 10 on mem_data is passed through unchanged.
//  Total latency start -> done pulse: 1 + 9 + N*N + N + 1 cycles (N=28: 823).
// CONFIGURATION
//  FMAP_STREAM_HOLD_EN defined: extra input hold (1 bit). While hold=1: mem_rd=0,
//   all counters and FSM frozen, pix_valid=0 and w_req=0 for the returned-data stage;
//   the in-flight read word is kept in a 1-entry skid register and emitted first after
//   hold falls, so no pixel/weight is lost or duplicated. Hold in IDLE/DONE: no effect.
//  Not defined: no hold port; stream is unconditionally one item per clock.
// TESTING
//  N=3, mem pixels 0..8 = 01,11,00,01,01,11,00,00,01, weights all 01, pulse start ->
//   9 w_req cycles then d_out sequence as stored with (x1,y1)=(0,0),(1,0)..(2,2), 3 flush
//   pixels y1=3, done at cycle 23 after start.
//  N=28 full frame -> exactly 784 pix_valid cycles with y1<28, 28 with y1=28, done once.
//  start with input_depth=2 and 29 -> err pulse, busy stays 0, no mem_rd.
//  Assert reset at pixel (5,10) of N=28 -> all outputs 0 same cycle; restart -> full
//   frame from (0,0), no stale done.
//  start held high continuously -> transfers run back-to-back, one per IDLE entry; start
//   pulses while busy change nothing.
//  FMAP_STREAM_HOLD_EN: hold=1 for 4 cycles at pixel (1,1), N=3 -> output order
//   identical to no-hold run, pixels after hold delayed exactly 4 cycles.

Source files
------------

// File: rtl/fmap_stream_tx.sv
// fmap_stream_tx: streams 9 kernel weights, one ternary raster frame and a zero flush row
// from a 1-cycle sync-read memory. Define FMAP_STREAM_HOLD_EN to add the 'hold' stall input.
module fmap_stream_tx #(
  parameter int DATA_WIDTH = 2,
  parameter int MAX_DIM    = 28,
  parameter int ADDR_W     = 10,
  parameter int WGT_BASE   = 784
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [4:0]            input_depth,
`ifdef FMAP_STREAM_HOLD_EN
  input  logic                  hold,
`endif
  output logic                  mem_rd,
  output logic [ADDR_W-1:0]     mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic [DATA_WIDTH-1:0] w_out,
  output logic                  w_req,
  output logic [DATA_WIDTH-1:0] d_out,
  output logic [4:0]            x1,
  output logic [4:0]            y1,
  output logic                  pix_valid,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WGT   = 3'd1;
  localparam logic [2:0] S_PIX   = 3'd2;
  localparam logic [2:0] S_FLUSH = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [1:0] K_WGT   = 2'd0;
  localparam logic [1:0] K_PIX   = 2'd1;
  localparam logic [1:0] K_FLUSH = 2'd2;

  logic [2:0]            state_q, state_d;
  logic [4:0]            n_q, n_d, x_q, x_d, y_q, y_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic                  err_q, err_d;
  // Return stage: describes the item whose read data is on mem_data this cycle.
  logic                  st_v_q, st_v_d;
  logic [1:0]            st_kind_q, st_kind_d;
  logic [4:0]            st_x_q, st_x_d, st_y_q, st_y_d;

  logic                  active, frozen, issue, depth_ok;
  logic [DATA_WIDTH-1:0] st_data;
  logic                  out_v;
  logic [1:0]            out_kind;
  logic [4:0]            out_x, out_y;
  logic [DATA_WIDTH-1:0] out_data;

  assign active   = (state_q == S_WGT) || (state_q == S_PIX) || (state_q == S_FLUSH);
  assign issue    = active && !frozen;
  assign depth_ok = (input_depth >= 5'd3) && (input_depth <= 5'(MAX_DIM));
  assign mem_rd   = issue && (state_q != S_FLUSH);
  assign mem_addr = mem_rd ? addr_q : '0;
  assign st_data  = (st_kind_q == K_FLUSH) ? '0 : mem_data;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch is inferred.
    state_d   = state_q;
    n_d       = n_q;
    x_d       = x_q;
    y_d       = y_q;
    addr_d    = addr_q;
    err_d     = 1'b0;
    st_v_d    = issue;
    st_kind_d = K_WGT;
    st_x_d    = x_q;
    st_y_d    = y_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (depth_ok) begin
            state_d = S_WGT;
            n_d     = input_depth;
            addr_d  = ADDR_W'(WGT_BASE);
            x_d     = '0;
            y_d     = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_WGT: begin
        st_kind_d = K_WGT;
        if (!frozen) begin
          addr_d = addr_q + ADDR_W'(1);
          x_d    = x_q + 5'd1;
          if (x_q == 5'd8) begin
            state_d = S_PIX;
            addr_d  = '0;
            x_d     = '0;
          end
        end
      end
      S_PIX: begin
        // Raster address y*N+x is just a running count, so no multiplier is needed.
        st_kind_d = K_PIX;
        if (!frozen) begin
          addr_d = addr_q + ADDR_W'(1);
          x_d    = x_q + 5'd1;
          if (x_q == n_q - 5'd1) begin
            x_d = '0;
            y_d = y_q + 5'd1;
            if (y_q == n_q - 5'd1) state_d = S_FLUSH;
          end
        end
      end
      S_FLUSH: begin
        st_kind_d = K_FLUSH;
        if (!frozen) begin
          x_d = x_q + 5'd1;
          if (x_q == n_q - 5'd1) begin
            state_d = S_DONE;
            x_d     = '0;
            y_d     = '0;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) begin
      state_q   <= S_IDLE;
      n_q       <= '0;
      x_q       <= '0;
      y_q       <= '0;
      addr_q    <= '0;
      err_q     <= 1'b0;
      st_v_q    <= 1'b0;
      st_kind_q <= K_WGT;
      st_x_q    <= '0;
      st_y_q    <= '0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      x_q       <= x_d;
      y_q       <= y_d;
      addr_q    <= addr_d;
      err_q     <= err_d;
      st_v_q    <= st_v_d;
      st_kind_q <= st_kind_d;
      st_x_q    <= st_x_d;
      st_y_q    <= st_y_d;
    end
  end

`ifdef FMAP_STREAM_HOLD_EN
  logic                  skid_v_q;
  logic [1:0]            skid_kind_q;
  logic [4:0]            skid_x_q, skid_y_q;
  logic [DATA_WIDTH-1:0] skid_data_q;

  assign frozen = hold && active;

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: only the valid bit needs reset; the payload is never observed while invalid.
    if (reset) begin
      skid_v_q <= 1'b0;
    end else if (frozen && st_v_q) begin
      skid_v_q    <= 1'b1;
      skid_kind_q <= st_kind_q;
      skid_x_q    <= st_x_q;
      skid_y_q    <= st_y_q;
      skid_data_q <= st_data;
    end else if (!frozen) begin
      skid_v_q <= 1'b0;
    end
  end

  // A parked word always goes out first; no new read returns in that same cycle.
  always_comb begin
    out_v    = st_v_q && !frozen;
    out_kind = st_kind_q;
    out_x    = st_x_q;
    out_y    = st_y_q;
    out_data = st_data;
    if (skid_v_q && !frozen) begin
      out_v    = 1'b1;
      out_kind = skid_kind_q;
      out_x    = skid_x_q;
      out_y    = skid_y_q;
      out_data = skid_data_q;
    end
  end
`else
  assign frozen   = 1'b0;
  assign out_v    = st_v_q;
  assign out_kind = st_kind_q;
  assign out_x    = st_x_q;
  assign out_y    = st_y_q;
  assign out_data = st_data;
`endif

  assign w_req     = out_v && (out_kind == K_WGT);
  assign pix_valid = out_v && (out_kind != K_WGT);
  assign w_out     = w_req ? out_data : '0;
  assign d_out     = pix_valid ? out_data : '0;
  assign x1        = pix_valid ? out_x : '0;
  assign y1        = pix_valid ? out_y : '0;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign err       = err_q;

endmodule

// File: tb/tb_fmap_stream_tx.sv
// Directed bench for fmap_stream_tx: sync-read memory model, negedge stream monitor,
// one task per scenario. Cycle 1 is the cycle in which start is first sampled.
module tb_fmap_stream_tx;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [4:0]  input_depth;
  logic        mem_rd;
  logic [9:0]  mem_addr;
  logic [1:0]  mem_data;
  logic [1:0]  w_out, d_out;
  logic        w_req, pix_valid, busy, done, err;
  logic [4:0]  x1, y1;
`ifdef FMAP_STREAM_HOLD_EN
  logic        hold;
`endif

  int errors = 0;
  int checks = 0;

  fmap_stream_tx dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .input_depth (input_depth),
`ifdef FMAP_STREAM_HOLD_EN
    .hold        (hold),
`endif
    .mem_rd      (mem_rd),
    .mem_addr    (mem_addr),
    .mem_data    (mem_data),
    .w_out       (w_out),
    .w_req       (w_req),
    .d_out       (d_out),
    .x1          (x1),
    .y1          (y1),
    .pix_valid   (pix_valid),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  always #5 clk = ~clk;

  logic [1:0] mem [0:1023];
  always @(posedge clk) if (mem_rd) mem_data <= mem[mem_addr];

  // Stream monitor
  int         cyc, done_cnt, err_cnt, err_cyc, rd_cnt, busy_cnt;
  int         dq[$];
  logic [1:0] wq[$];
  int         wcyc[$];
  logic [11:0] pq[$];
  int         pcyc[$];

  always @(negedge clk) begin
    cyc++;
    if (w_req) begin wq.push_back(w_out); wcyc.push_back(cyc); end
    if (pix_valid) begin pq.push_back({y1, x1, d_out}); pcyc.push_back(cyc); end
    if (done) begin done_cnt++; dq.push_back(cyc); end
    if (err) begin err_cnt++; err_cyc = cyc; end
    if (mem_rd) rd_cnt++;
    if (busy) busy_cnt++;
  end

  task automatic clear_log();
    cyc = 0; done_cnt = 0; err_cnt = 0; err_cyc = 0; rd_cnt = 0; busy_cnt = 0;
    dq.delete(); wq.delete(); wcyc.delete(); pq.delete(); pcyc.delete();
  endtask

  task automatic start_xfer(input logic [4:0] n);
    @(posedge clk); #1;
    clear_log();
    input_depth = n;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    bit ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(posedge clk); #1;
      if (done_cnt > 0) ok = 1;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: done not seen within %0d cycles, required done pulse", name, budget);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  function automatic logic [29:0] all_outs();
    return {mem_rd, busy, done, err, w_req, pix_valid, w_out, d_out, x1, y1, mem_addr};
  endfunction

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; input_depth = 5'd3;
    #1;
    checks++;
    if (all_outs() !== 30'd0) begin
      errors++; $display("FAIL reset_outs: got %h required 0", all_outs());
    end
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (all_outs() !== 30'd0) begin
      errors++; $display("FAIL idle_outs: got %h required 0", all_outs());
    end
  endtask

  task automatic test_basic_n3();
    logic [1:0] pix [0:8];
    logic [11:0] exp_e;
    int bad_w = 0, bad_p = 0;
    pix = '{2'b01, 2'b11, 2'b00, 2'b01, 2'b01, 2'b11, 2'b00, 2'b00, 2'b01};
    for (int i = 0; i < 9; i++) begin mem[i] = pix[i]; mem[784 + i] = 2'b01; end
    start_xfer(5'd3);
    wait_done(60, "n3_done_seen");
    checks++;
    if (wq.size() !== 9) begin errors++; $display("FAIL n3_wcount: got %0d required 9", wq.size()); end
    for (int i = 0; i < 9 && i < wq.size(); i++)
      if (wq[i] !== 2'b01 || wcyc[i] != 3 + i) bad_w++;
    checks++;
    if (bad_w != 0) begin errors++; $display("FAIL n3_weights: %0d bad weights, required 0", bad_w); end
    checks++;
    if (pq.size() !== 12) begin errors++; $display("FAIL n3_pcount: got %0d required 12", pq.size()); end
    for (int i = 0; i < 12 && i < pq.size(); i++) begin
      exp_e = (i < 9) ? {5'(i / 3), 5'(i % 3), pix[i]} : {5'd3, 5'(i - 9), 2'b00};
      if (pq[i] !== exp_e || pcyc[i] != 12 + i) begin
        bad_p++;
        $display("FAIL n3_pix%0d: got %h at cyc %0d required %h at cyc %0d",
                 i, pq[i], pcyc[i], exp_e, 12 + i);
      end
    end
    checks++;
    if (bad_p != 0) errors++;
    checks++;
    if (done_cnt != 1 || dq[0] != 23) begin
      errors++; $display("FAIL n3_done: got %0d pulses at cyc %0d required 1 at 23", done_cnt, dq[0]);
    end
    checks++;
    if (rd_cnt != 18) begin errors++; $display("FAIL n3_reads: got %0d required 18", rd_cnt); end
    checks++;
    if (all_outs() !== 30'd0) begin errors++; $display("FAIL n3_idle: got %h required 0", all_outs()); end
  endtask

  task automatic test_bad_depth();
    logic [4:0] bad [0:1];
    bad = '{5'd2, 5'd29};
    for (int k = 0; k < 2; k++) begin
      start_xfer(bad[k]);
      repeat (6) @(posedge clk);
      #1;
      checks++;
      if (err_cnt != 1 || err_cyc != 2) begin
        errors++;
        $display("FAIL bad_depth%0d_err: got %0d pulses at cyc %0d required 1 at 2", bad[k], err_cnt, err_cyc);
      end
      checks++;
      if (busy_cnt != 0 || rd_cnt != 0) begin
        errors++;
        $display("FAIL bad_depth%0d_idle: busy=%0d reads=%0d required 0/0", bad[k], busy_cnt, rd_cnt);
      end
    end
  endtask

  task automatic test_full_frame();
    int inner = 0, flush = 0, bad = 0;
    logic [11:0] exp_e;
    for (int i = 0; i < 784; i++) mem[i] = 2'((i * 7 + i / 28) % 4);
    start_xfer(5'd28);
    wait_done(900, "n28_done_seen");
    for (int i = 0; i < pq.size(); i++) begin
      if (pq[i][11:7] < 5'd28) inner++;
      else if (pq[i][11:7] == 5'd28) flush++;
      exp_e = (i < 784) ? {5'(i / 28), 5'(i % 28), mem[i]} : {5'd28, 5'(i - 784), 2'b00};
      if (pq[i] !== exp_e) begin
        if (bad == 0) $display("FAIL n28_pix%0d: got %h required %h", i, pq[i], exp_e);
        bad++;
      end
    end
    checks++;
    if (inner != 784 || flush != 28) begin
      errors++; $display("FAIL n28_counts: got %0d/%0d required 784/28", inner, flush);
    end
    checks++;
    if (bad != 0) errors++;
    checks++;
    if (done_cnt != 1 || dq[0] != 823) begin
      errors++; $display("FAIL n28_done: got %0d pulses at cyc %0d required 1 at 823", done_cnt, dq[0]);
    end
  endtask

  task automatic test_reset_mid();
    bit found = 0;
    start_xfer(5'd28);
    for (int i = 0; i < 1000 && !found; i++) begin
      @(negedge clk);
      if (pix_valid && x1 == 5'd5 && y1 == 5'd10) found = 1;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL rstmid_reach: pixel (5,10) not seen, required seen"); end
    reset = 1'b1;
    #1;
    checks++;
    if (all_outs() !== 30'd0) begin
      errors++; $display("FAIL rstmid_outs: got %h required 0", all_outs());
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    clear_log();
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (done_cnt != 0 || busy_cnt != 0) begin
      errors++; $display("FAIL rstmid_stale: done=%0d busy=%0d required 0/0", done_cnt, busy_cnt);
    end
    start_xfer(5'd28);
    wait_done(900, "rstmid_done_seen");
    checks++;
    if (pq.size() != 812 || pq[0] !== {5'd0, 5'd0, mem[0]} || done_cnt != 1) begin
      errors++;
      $display("FAIL rstmid_restart: got %0d pix first %h done %0d required 812 %h 1",
               pq.size(), pq[0], done_cnt, {5'd0, 5'd0, mem[0]});
    end
  endtask

  task automatic test_back_to_back();
    @(posedge clk); #1;
    clear_log();
    input_depth = 5'd3;
    start = 1'b1;
    for (int i = 1; i < 40; i++) begin
      @(posedge clk); #1;
      if (i == 5) input_depth = 5'd9;
      if (i == 15) input_depth = 5'd3;
    end
    start = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    checks++;
    if (done_cnt != 2 || dq[0] != 23 || dq[1] != 46) begin
      errors++;
      $display("FAIL b2b_done: got %0d pulses at %0d,%0d required 2 at 23,46", done_cnt, dq[0], dq[1]);
    end
    checks++;
    if (pq.size() != 24 || wq.size() != 18) begin
      errors++; $display("FAIL b2b_counts: got pix=%0d w=%0d required 24/18", pq.size(), wq.size());
    end
  endtask

`ifdef FMAP_STREAM_HOLD_EN
  task automatic test_hold();
    int bad = 0, exp_c;
    logic [11:0] exp_e;
    for (int i = 0; i < 9; i++) mem[i] = 2'(i % 4);
    @(posedge clk); #1;
    clear_log();
    input_depth = 5'd3;
    start = 1'b1;
    for (int i = 1; i < 25; i++) begin
      @(posedge clk); #1;
      if (i == 1) start = 1'b0;
      if (i == 15) hold = 1'b1;
      if (i == 19) hold = 1'b0;
    end
    wait_done(40, "hold_done_seen");
    for (int i = 0; i < 12 && i < pq.size(); i++) begin
      exp_e = (i < 9) ? {5'(i / 3), 5'(i % 3), mem[i]} : {5'd3, 5'(i - 9), 2'b00};
      exp_c = (12 + i >= 16) ? 16 + i : 12 + i;
      if (pq[i] !== exp_e || pcyc[i] != exp_c) begin
        bad++;
        $display("FAIL hold_pix%0d: got %h at %0d required %h at %0d", i, pq[i], pcyc[i], exp_e, exp_c);
      end
    end
    checks++;
    if (bad != 0 || pq.size() != 12) begin
      errors++; $display("FAIL hold_stream: got %0d pix %0d bad required 12/0", pq.size(), bad);
    end
    checks++;
    if (done_cnt != 1 || dq[0] != 27 || rd_cnt != 18) begin
      errors++;
      $display("FAIL hold_done: got %0d at %0d reads %0d required 1 at 27 reads 18", done_cnt, dq[0], rd_cnt);
    end
  endtask
`endif

  initial begin
    mem_data = 2'b00;
`ifdef FMAP_STREAM_HOLD_EN
    hold = 1'b0;
`endif
    for (int i = 0; i < 1024; i++) mem[i] = 2'b00;
    test_reset();
    test_basic_n3();
    test_bad_depth();
    test_full_frame();
    test_reset_mid();
    test_back_to_back();
`ifdef FMAP_STREAM_HOLD_EN
    test_hold();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
